conv_pixel_streamer: RTL and testbench

Upstream sequencer for the 3x3 convolution accelerator. It holds one IMG_WIDTH x IMG_HEIGHT frame written by the CPU over the memory-mapped bus. On start it clears the accelerator, streams every pixel into it with a write-then-read-back sequence, and stores each returned result in a local result buffer for the CPU to read. Weight writes from the CPU pass through to the accelerator while the block is idle.

---
 rtl/conv_stream_pkg.sv | 35 +++
 rtl/conv_pixel_streamer_stream_buf.sv | 26 ++
 rtl/conv_pixel_streamer.sv | 159 +++++++++++++++
 tb/tb_conv_pixel_streamer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_pkg.sv
// Shared constants and types for the convolution pixel streamer:
// host address map, accelerator register map and the sequencer states.
package conv_stream_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int IDX_W     = 6;

  localparam logic [7:0] PIX_BASE  = 8'h00;
  localparam logic [7:0] CTRL      = 8'h40;
  localparam logic [7:0] STATUS    = 8'h41;
  localparam logic [7:0] RES_BASE  = 8'h80;
  localparam logic [7:0] PASS_BASE = 8'hC0;

  localparam logic [3:0] ACC_DATA   = 4'd0;
  localparam logic [3:0] ACC_RESULT = 4'd1;
  localparam logic [3:0] ACC_CLEAR  = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PUSH,
    ST_READ,
    ST_CAPTURE
  } state_t;

  // Buffers occupy 64-entry windows aligned on the top two address bits.
  function automatic logic in_buf_window(input logic [7:0] a, input logic [7:0] base);
    return a[7:6] == base[7:6];
  endfunction

  function automatic logic in_pass_window(input logic [7:0] a);
    return a[7:4] == PASS_BASE[7:4];
  endfunction

endpackage

// File: rtl/conv_pixel_streamer_stream_buf.sv
// 64-entry register array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a frame survives a sequencer reset.
module stream_buf
  import conv_stream_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_pixel_streamer.sv
// Sequencer that clears the 3x3 convolution accelerator, streams a stored frame
// through it pixel by pixel and captures each result for the host to read back.
module conv_pixel_streamer
  import conv_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [7:0]    addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          acc_en,
  output logic          acc_we,
  output logic [3:0]    acc_addr,
  output logic [DW-1:0] acc_din,
  input  logic [DW-1:0] acc_dout
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(IMG_WIDTH * IMG_HEIGHT - 1);

  state_t           state;
  logic [IDX_W-1:0] k;
  logic             done;
  logic             busy;

  logic             host_wr, host_rd;
  logic             is_pix, is_res, is_pass, is_ctrl, is_status;
  logic             start_req, clr_req, pix_we, res_we;
  logic [DW-1:0]    pix_rd, res_rd;
  logic [DW-1:0]    status_word;

  assign busy      = (state != ST_IDLE);
  assign host_wr   = en & we;
  assign host_rd   = en & ~we;
  assign is_pix    = in_buf_window(addr, PIX_BASE);
  assign is_res    = in_buf_window(addr, RES_BASE);
  assign is_pass   = in_pass_window(addr);
  assign is_ctrl   = (addr == CTRL);
  assign is_status = (addr == STATUS);

  assign start_req = host_wr & is_ctrl & din[0] & ~busy;
  assign clr_req   = host_wr & is_ctrl & din[1];
  assign pix_we    = host_wr & is_pix & ~busy;
  assign res_we    = (state == ST_CAPTURE);

  stream_buf #(.DW(DW)) u_pix_buf (
    .clk  (clk),
    .we   (pix_we),
    .waddr(addr[IDX_W-1:0]),
    .wdata(din),
    .raddr(k),
    .rdata(pix_rd)
  );

  stream_buf #(.DW(DW)) u_res_buf (
    .clk  (clk),
    .we   (res_we),
    .waddr(k),
    .wdata(acc_dout),
    .raddr(addr[IDX_W-1:0]),
    .rdata(res_rd)
  );

  // Sequencer: CLEAR once, then PUSH/READ/CAPTURE per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      done  <= 1'b0;
    end else begin
      if (clr_req) begin
        done <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state <= ST_CLEAR;
            k     <= '0;
            done  <= 1'b0;
          end
        end
        ST_CLEAR: state <= ST_PUSH;
        ST_PUSH:  state <= ST_READ;
        ST_READ:  state <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (k == K_LAST) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            k     <= k + 1'b1;
            state <= ST_PUSH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = busy;
    status_word[1]    = done;
    status_word[13:8] = k;
  end

  // Host read data: a result-buffer read alongside CAPTURE sees the pre-write entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (host_rd && is_status) begin
      dout <= status_word;
    end else if (host_rd && is_res) begin
      dout <= res_rd;
    end else begin
      dout <= '0;
    end
  end

  always_comb begin
    acc_en   = 1'b0;
    acc_we   = 1'b0;
    acc_addr = '0;
    acc_din  = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (en && is_pass) begin
            acc_en   = 1'b1;
            acc_we   = we;
            acc_addr = addr[3:0];
            acc_din  = din;
          end
        end
        ST_CLEAR: begin
          acc_en   = 1'b1;
          acc_we   = 1'b1;
          acc_addr = ACC_CLEAR;
        end
        ST_PUSH: begin
          acc_en   = 1'b1;
          acc_we   = 1'b1;
          acc_addr = ACC_DATA;
          acc_din  = pix_rd;
        end
        ST_READ: begin
          acc_en   = 1'b1;
          acc_addr = ACC_RESULT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pixel_streamer.sv
// Directed bench for conv_pixel_streamer with a behavioural accelerator that
// answers each result read with mult x the last pushed pixel.
module tb_conv_pixel_streamer;

  logic        clk;
  logic        rst;
  logic        en, we;
  logic [7:0]  addr;
  logic [31:0] din, dout;
  logic        acc_en, acc_we;
  logic [3:0]  acc_addr;
  logic [31:0] acc_din, acc_dout;

  logic [31:0] last_pix;
  logic [31:0] mult;

  int checks   = 0;
  int failures = 0;

  conv_pixel_streamer #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DW(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .acc_en  (acc_en),
    .acc_we  (acc_we),
    .acc_addr(acc_addr),
    .acc_din (acc_din),
    .acc_dout(acc_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (acc_en && acc_we && acc_addr == 4'd0) last_pix <= acc_din;
    if (acc_en && !acc_we && acc_addr == 4'd1) acc_dout <= last_pix * mult;
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        exp_acc_en;
    logic [31:0] exp_dout;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Compares acc_en alone when idle is expected, the full access otherwise.
  task automatic chk_acc(input string nm, input logic e, input logic w,
                         input logic [3:0] a, input logic [31:0] d, input logic cmp_d);
    if (!e) chk(nm, {63'd0, acc_en}, 64'd0);
    else chk(nm, {25'd0, acc_en, acc_we, acc_addr, (cmp_d ? acc_din : 32'd0)},
             {25'd0, 1'b1, w, a, (cmp_d ? d : 32'd0)});
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    en = 1'b1; we = 1'b1; addr = a; din = d;
    step();
    en = 1'b0; we = 1'b0;
  endtask

  task automatic host_rd(input logic [7:0] a, output logic [31:0] d);
    en = 1'b1; we = 1'b0; addr = a; din = '0;
    step();
    en = 1'b0;
    d = dout;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] rd;
    int          p, kk;

    vecs[0] = '{we:1'b0, addr:8'h41, din:32'h0,        exp_acc_en:1'b0, exp_dout:32'h0};
    vecs[1] = '{we:1'b1, addr:8'hCB, din:32'h1,        exp_acc_en:1'b1, exp_dout:32'h0};
    vecs[2] = '{we:1'b0, addr:8'hC3, din:32'h0,        exp_acc_en:1'b1, exp_dout:32'h0};
    vecs[3] = '{we:1'b0, addr:8'h50, din:32'h0,        exp_acc_en:1'b0, exp_dout:32'h0};
    vecs[4] = '{we:1'b0, addr:8'h05, din:32'h0,        exp_acc_en:1'b0, exp_dout:32'h0};
    vecs[5] = '{we:1'b1, addr:8'h42, din:32'h3,        exp_acc_en:1'b0, exp_dout:32'h0};
    vecs[6] = '{we:1'b0, addr:8'hD0, din:32'h0,        exp_acc_en:1'b0, exp_dout:32'h0};
    vecs[7] = '{we:1'b1, addr:8'hCF, din:32'hDEADBEEF, exp_acc_en:1'b1, exp_dout:32'h0};

    mult = 32'd3;
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_acc_en", {63'd0, acc_en}, 64'd0);
    chk("reset_dout", {32'd0, dout}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      en = 1'b1; we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din;
      #1;
      chk_acc($sformatf("vec%0d_acc", i), vecs[i].exp_acc_en, vecs[i].we,
              vecs[i].addr[3:0], vecs[i].din, 1'b1);
      step();
      en = 1'b0;
      chk($sformatf("vec%0d_dout", i), {32'd0, dout}, {32'd0, vecs[i].exp_dout});
    end

    for (int i = 0; i < 64; i++) host_wr(8'(i), 32'(i + 1));

    // Run 1: start sampled at edge T; loop index c is the cycle T+c.
    en = 1'b1; we = 1'b1; addr = 8'h40; din = 32'h1;
    step();
    for (int c = 1; c <= 196; c++) begin
      en = 1'b0; we = 1'b0; addr = '0; din = '0;
      case (c)
        10:  begin en = 1'b1; we = 1'b1; addr = 8'h05; din = 32'hFF; end
        11:  begin en = 1'b1; we = 1'b1; addr = 8'hC2; din = 32'h77; end
        50:  begin en = 1'b1; we = 1'b1; addr = 8'h40; din = 32'h1;  end
        100, 193, 194: begin en = 1'b1; we = 1'b0; addr = 8'h41; end
        default: ;
      endcase
      #1;
      if (c == 1) chk_acc("run1_clear", 1'b1, 1'b1, 4'd2, 32'd0, 1'b1);
      else if (c >= 2 && c <= 193) begin
        p  = (c - 2) % 3;
        kk = (c - 2) / 3;
        if (p == 0)      chk_acc($sformatf("run1_push_c%0d", c), 1'b1, 1'b1, 4'd0, 32'(kk + 1), 1'b1);
        else if (p == 1) chk_acc($sformatf("run1_read_c%0d", c), 1'b1, 1'b0, 4'd1, 32'd0, 1'b0);
        else             chk_acc($sformatf("run1_capt_c%0d", c), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
      end else chk_acc($sformatf("run1_idle_c%0d", c), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
      case (c)
        51:  chk("run1_dout_after_start", {32'd0, dout}, 64'd0);
        101: chk("run1_status_mid", {32'd0, dout}, 64'h2001);
        194: chk("run1_status_t193", {32'd0, dout}, 64'h3F01);
        195: chk("run1_status_done", {32'd0, dout}, 64'h3F02);
        196: chk("run1_dout_returns_0", {32'd0, dout}, 64'd0);
        default: ;
      endcase
      step();
    end

    for (int i = 0; i < 64; i++) begin
      host_rd(8'(8'h80 + i), rd);
      chk($sformatf("run1_res%0d", i), {32'd0, rd}, {32'd0, 32'(3 * (i + 1))});
    end

    // Start and clear together after done: new run begins, done drops.
    mult = 32'd5;
    host_wr(8'h40, 32'h3);
    chk_acc("run2_clear", 1'b1, 1'b1, 4'd2, 32'd0, 1'b1);
    host_rd(8'h41, rd);
    chk("run2_status", {32'd0, rd}, 64'h0001);
    chk_acc("run2_push0", 1'b1, 1'b1, 4'd0, 32'd1, 1'b1);
    repeat (97) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk_acc($sformatf("abort_acc%0d", i), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
      step();
    end
    host_rd(8'h41, rd);
    chk("abort_status", {32'd0, rd}, 64'd0);

    // Run 3 from the retained pixel buffer.
    host_wr(8'h40, 32'h1);
    chk_acc("run3_clear", 1'b1, 1'b1, 4'd2, 32'd0, 1'b1);
    repeat (192) step();
    host_rd(8'h41, rd);
    chk("run3_status_t193", {32'd0, rd}, 64'h3F01);
    host_rd(8'h41, rd);
    chk("run3_status_done", {32'd0, rd}, 64'h3F02);
    for (int i = 0; i < 64; i++) begin
      host_rd(8'(8'h80 + i), rd);
      chk($sformatf("run3_res%0d", i), {32'd0, rd}, {32'd0, 32'(5 * (i + 1))});
    end

    host_wr(8'h40, 32'h2);
    host_rd(8'h41, rd);
    chk("clear_done_status", {32'd0, rd}, 64'h3F00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
